key_cycle_fsm: RTL and testbench

KEY_CYCLE_FSM -- requirements
Module: key_cycle_fsm

---
 rtl/key_pkg.sv | 22 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/key_cycle_fsm.sv | 117 +++++++++++
 tb/tb_key_cycle_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key-driven state cycler.
package key_pkg;

  // Level of an idle key. The keys are active-low, so this is also the
  // level the synchronisers and debouncers return to on reset.
  localparam logic KEY_RELEASED = 1'b1;

  // Step request decoded from the two press events. The value is {next, prev}.
  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_PREV = 2'b01,
    STEP_NEXT = 2'b10,
    STEP_BOTH = 2'b11
  } step_e;

  // Width of a debounce counter that only has to hold 0..cycles-1.
  // It is never narrower than one bit, so DEBOUNCE_CYCLES=1 still gets a legal vector.
  function automatic int dbc_width(input int cycles);
    return (cycles <= 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One raw active-low key in; a one-cycle press pulse out.
// The path is a 2-FF synchroniser, then an up-counting debouncer, then a
// registered falling-edge detector on the debounced level.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int            CW = dbc_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  logic w_diff;
  logic w_tc;

  // The level flips on the edge that would complete DEBOUNCE_CYCLES consecutive
  // differing samples. The press pulse is set on that same edge, so the consumer
  // sees the pulse in the first cycle of the new debounced level.
  assign w_diff = (r_sync2 != r_level);
  assign w_tc   = w_diff && (r_cnt == TC);

  // Synchroniser, debounce counter, debounced level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= KEY_RELEASED;
      r_sync2 <= KEY_RELEASED;
      r_level <= KEY_RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      if (!w_diff || w_tc) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_tc) begin
        r_level <= r_sync2;
      end
      // A release (the level going back to 1) produces no pulse.
      r_press <= w_tc && (r_sync2 != KEY_RELEASED);
    end
  end

  assign press = r_press;

endmodule

// File: rtl/key_cycle_fsm.sv
// State cycler driven by two debounced keys. key_next steps the state up and
// key_prev steps it down. At either end the state wraps or saturates,
// depending on wrap_en. A synchronous load overrides the keys when its value
// is in range; an out-of-range load is rejected and flagged on load_err.
module key_cycle_fsm
  import key_pkg::*;
#(
  parameter int N_STATES        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW              = $clog2(N_STATES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_next,
  input  logic          key_prev,
  input  logic          wrap_en,
  input  logic          load_en,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] state,
  output logic          wrap_pulse,
  output logic          load_err
);

  localparam logic [SW-1:0] LAST    = SW'(N_STATES - 1);
  localparam logic [SW:0]   N_WIDE  = (SW + 1)'(N_STATES);

  logic [SW-1:0] r_state;
  logic          r_wrap;
  logic          r_load_err;

  logic          w_ev_next;
  logic          w_ev_prev;
  step_e         w_step;
  logic          w_load_ok;
  logic [SW-1:0] w_state_nxt;
  logic          w_wrap_nxt;
  logic          w_err_nxt;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbc_next (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_next),
    .press  (w_ev_next)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_dbc_prev (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_raw(key_prev),
    .press  (w_ev_prev)
  );

  assign w_step = step_e'({w_ev_next, w_ev_prev});

  // The range check is done one bit wider, so it stays meaningful when
  // N_STATES is a power of two.
  assign w_load_ok = load_en && ({1'b0, load_val} < N_WIDE);

  // Next state: a valid load wins; otherwise apply the key step with wrap or saturate.
  always_comb begin
    w_state_nxt = r_state;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_load_ok) begin
      w_state_nxt = load_val;
    end else begin
      w_err_nxt = load_en;
      case (w_step)
        STEP_NEXT: begin
          if (r_state == LAST) begin
            if (wrap_en) begin
              w_state_nxt = '0;
              w_wrap_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = r_state + 1'b1;
          end
        end
        STEP_PREV: begin
          if (r_state == '0) begin
            if (wrap_en) begin
              w_state_nxt = LAST;
              w_wrap_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = r_state - 1'b1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State vector and the one-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_err_nxt;
    end
  end

  assign state      = r_state;
  assign wrap_pulse = r_wrap;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_key_cycle_fsm.sv
module tb_key_cycle_fsm;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int SW = $clog2(N);
  localparam int LAT = 3 + D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_next = 1'b1;
  logic          key_prev = 1'b1;
  logic          wrap_en = 1'b0;
  logic          load_en = 1'b0;
  logic [SW-1:0] load_val = '0;
  logic [SW-1:0] state;
  logic          wrap_pulse;
  logic          load_err;

  int vectors = 0;
  int miscompares = 0;
  int wrap_cnt = 0;
  int err_cnt = 0;
  int exp_s = 0;

  key_cycle_fsm #(
    .N_STATES       (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_next  (key_next),
    .key_prev  (key_prev),
    .wrap_en   (wrap_en),
    .load_en   (load_en),
    .load_val  (load_val),
    .state     (state),
    .wrap_pulse(wrap_pulse),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrap_pulse === 1'b1) wrap_cnt++;
    if (load_err === 1'b1) err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference behaviour: +1 / -1 with wrap or saturate at 0 and N-1.
  function automatic int model_step(input int s, input int dir, input bit wrap, output bit wrapped);
    wrapped = 1'b0;
    if (dir > 0) begin
      if (s == N - 1) begin
        wrapped = wrap;
        return wrap ? 0 : s;
      end
      return s + 1;
    end else begin
      if (s == 0) begin
        wrapped = wrap;
        return wrap ? N - 1 : s;
      end
      return s - 1;
    end
  endfunction

  // A clean press: hold long enough to be accepted, then release and settle.
  task automatic press(input bit nxt, input bit prv);
    key_next = nxt ? 1'b0 : 1'b1;
    key_prev = prv ? 1'b0 : 1'b1;
    repeat (LAT + 3) tick();
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (LAT + 2) tick();
  endtask

  task automatic do_load(input int v);
    load_en  = 1'b1;
    load_val = SW'(v);
    tick();
    load_en  = 1'b0;
    tick();
  endtask

  initial begin
    int w0, e0, op, v;
    bit wr;

    // Reset state
    #3;
    chk("reset_state", int'(state), 0);
    chk("reset_wrap", int'(wrap_pulse), 0);
    chk("reset_err", int'(load_err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Scenario 1: exact latency, then a single event while the key is held
    key_next = 1'b0;
    repeat (LAT - 1) tick();
    chk("s1_before_latency", int'(state), 0);
    tick();
    chk("s1_at_latency", int'(state), 1);
    repeat (50) tick();
    chk("s1_held_no_repeat", int'(state), 1);
    key_next = 1'b1;
    repeat (LAT + 2) tick();

    // Scenario 2: wrap over five presses from 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wrap_en = 1'b1;
    exp_s = 0;
    for (int i = 0; i < 5; i++) begin
      w0 = wrap_cnt;
      press(1'b1, 1'b0);
      exp_s = model_step(exp_s, 1, 1'b1, wr);
      chk("s2_state", int'(state), exp_s);
      chk("s2_wrap_cycles", wrap_cnt - w0, wr ? 1 : 0);
    end
    chk("s2_final_zero", int'(state), 0);

    // Scenario 3: saturation at both ends
    wrap_en = 1'b0;
    w0 = wrap_cnt;
    press(1'b0, 1'b1);
    chk("s3_prev_sat", int'(state), 0);
    do_load(4);
    chk("s3_load4", int'(state), 4);
    press(1'b1, 1'b0);
    chk("s3_next_sat", int'(state), 4);
    chk("s3_no_wrap", wrap_cnt - w0, 0);

    // Scenario 4: short glitches, then simultaneous presses
    repeat (10) begin
      key_next = 1'b0;
      repeat (D - 1) tick();
      key_next = 1'b1;
      repeat (D - 1) tick();
    end
    repeat (LAT) tick();
    chk("s4_glitch", int'(state), 4);
    press(1'b1, 1'b1);
    chk("s4_both", int'(state), 4);

    // Scenario 5: rejected load, then a valid load beating a key event
    e0 = err_cnt;
    do_load(6);
    chk("s5_err_once", err_cnt - e0, 1);
    chk("s5_held", int'(state), 4);
    key_next = 1'b0;
    repeat (LAT - 1) tick();
    load_en  = 1'b1;
    load_val = 3'd3;
    tick();
    load_en  = 1'b0;
    chk("s5_load_wins", int'(state), 3);
    repeat (10) tick();
    key_next = 1'b1;
    repeat (LAT + 2) tick();
    chk("s5_event_dropped", int'(state), 3);
    // Rejected load with a coincident event: the event still applies
    e0 = err_cnt;
    key_next = 1'b0;
    repeat (LAT - 1) tick();
    load_en  = 1'b1;
    load_val = 3'd7;
    tick();
    load_en  = 1'b0;
    chk("s5_reject_keeps_event", int'(state), 4);
    key_next = 1'b1;
    repeat (LAT + 2) tick();
    chk("s5_reject_err", err_cnt - e0, 1);

    // Scenario 6: asynchronous reset mid-debounce with the key still held
    key_next = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #2;
    chk("s6_async_state", int'(state), 0);
    chk("s6_async_wrap", int'(wrap_pulse), 0);
    chk("s6_async_err", int'(load_err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (LAT - 1) tick();
    chk("s6_before_latency", int'(state), 0);
    tick();
    chk("s6_at_latency", int'(state), 1);
    repeat (20) tick();
    chk("s6_single_event", int'(state), 1);
    key_next = 1'b1;
    repeat (LAT + 2) tick();

    // Randomized operations against the reference model
    exp_s = 1;
    for (int i = 0; i < 40; i++) begin
      wrap_en = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 4);
      w0 = wrap_cnt;
      e0 = err_cnt;
      wr = 1'b0;
      case (op)
        0: begin
          press(1'b1, 1'b0);
          exp_s = model_step(exp_s, 1, wrap_en, wr);
        end
        1: begin
          press(1'b0, 1'b1);
          exp_s = model_step(exp_s, -1, wrap_en, wr);
        end
        2: press(1'b1, 1'b1);
        3: begin
          v = $urandom_range(1, D - 1);
          if ($urandom_range(0, 1) == 0) key_next = 1'b0; else key_prev = 1'b0;
          repeat (v) tick();
          key_next = 1'b1;
          key_prev = 1'b1;
          repeat (LAT + 2) tick();
        end
        default: begin
          v = $urandom_range(0, 7);
          do_load(v);
          if (v < N) exp_s = v;
        end
      endcase
      chk("rnd_state", int'(state), exp_s);
      chk("rnd_wrap", wrap_cnt - w0, wr ? 1 : 0);
      chk("rnd_err", err_cnt - e0, (op == 4 && v >= N) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
